// File: rtl/ipsxe_floating_point_axi_buffer_nio_v2_0.sv
// N-channel AXI-Stream join buffer: one FIFO per input channel, one output
// beat formed when every channel holds data, popping all channels together.
module ipsxe_floating_point_axi_buffer_nio_v2_0 #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                                i_aclk,
    input  logic                                i_areset,
    input  logic [NUM_CH*DATA_WIDTH-1:0]        i_tdata,
    input  logic [NUM_CH-1:0]                   i_tvalid,
    output logic [NUM_CH-1:0]                   o_tready,
    input  logic                                i_flush,
    output logic [NUM_CH*DATA_WIDTH-1:0]        o_tdata,
    output logic                                o_tvalid,
    input  logic                                i_tready,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0]    o_level
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

    // Storage spans the full address space; entries at DEPTH and above stay unused
    logic [DATA_WIDTH-1:0] mem_q [NUM_CH][2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] wptr_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] wptr_d [NUM_CH];
    logic [ADDR_WIDTH-1:0] rptr_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] rptr_d [NUM_CH];
    logic [CW-1:0]         cnt_q  [NUM_CH];
    logic [CW-1:0]         cnt_d  [NUM_CH];
    logic [NUM_CH-1:0]     tready_q, tready_d;
    logic                  tvalid_q, tvalid_d;
    logic [NUM_CH*DATA_WIDTH-1:0] tdata_q, tdata_d;

    logic [NUM_CH-1:0] push;
    logic              all_ne;
    logic              load;

    // Pointer advance with wrap at DEPTH-1 so non-power-of-two depths work
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_C) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // Handshake decode: per-channel push and the joint pop/load condition
    always_comb begin
        all_ne = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cnt_q[k] == '0) all_ne = 1'b0;
        end
        push = i_tvalid & tready_q & {NUM_CH{~i_flush}};
        load = all_ne & (~tvalid_q | i_tready) & ~i_flush;
    end

    // Next-state for pointers, counters, ready and the output register
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        if (load) begin
            tvalid_d = 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                tdata_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k][rptr_q[k]];
            end
        end else if (i_tready) begin
            tvalid_d = 1'b0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            wptr_d[k]   = push[k] ? ptr_inc(wptr_q[k]) : wptr_q[k];
            rptr_d[k]   = load    ? ptr_inc(rptr_q[k]) : rptr_q[k];
            cnt_d[k]    = cnt_q[k] + CW'(push[k]) - CW'(load);
            tready_d[k] = (cnt_d[k] != DEPTH_C);
        end
        // Flush outranks everything but deliberately keeps the last output data
        if (i_flush) begin
            tvalid_d = 1'b0;
            tready_d = '1;
            for (int k = 0; k < NUM_CH; k++) begin
                wptr_d[k] = '0;
                rptr_d[k] = '0;
                cnt_d[k]  = '0;
            end
        end
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tready_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tready_q <= tready_d;
            for (int k = 0; k < NUM_CH; k++) begin
                wptr_q[k] <= wptr_d[k];
                rptr_q[k] <= rptr_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    // FIFO storage write; contents are never reset
    always_ff @(posedge i_aclk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (push[k]) mem_q[k][wptr_q[k]] <= i_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Occupancy report straight from the counters
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            o_level[k*CW +: CW] = cnt_q[k];
        end
    end

    assign o_tready = tready_q;
    assign o_tvalid = tvalid_q;
    assign o_tdata  = tdata_q;

`ifndef SYNTHESIS
    // A push into a full channel must never happen
    always_ff @(posedge i_aclk) begin
        if (!i_areset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                assert (!(push[k] && cnt_q[k] == DEPTH_C));
            end
        end
    end
`endif

endmodule

// File: tb/tb_ipsxe_floating_point_axi_buffer_nio_v2_0.sv
// Directed bench for the N-channel join buffer (3 channels, 8-bit, depth 4).
module tb_ipsxe_floating_point_axi_buffer_nio_v2_0;

    localparam int NCH = 3;
    localparam int DW  = 8;
    localparam int DEP = 4;
    localparam int AW  = 2;
    localparam int CW  = AW + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*DW-1:0]    i_tdata;
    logic [NCH-1:0]       i_tvalid;
    logic [NCH-1:0]       o_tready;
    logic                 i_flush;
    logic [NCH*DW-1:0]    o_tdata;
    logic                 o_tvalid;
    logic                 i_tready;
    logic [NCH*CW-1:0]    o_level;

    int errors = 0;
    int checks = 0;

    ipsxe_floating_point_axi_buffer_nio_v2_0 #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW)
    ) dut (
        .i_aclk(clk), .i_areset(rst), .i_tdata(i_tdata), .i_tvalid(i_tvalid),
        .o_tready(o_tready), .i_flush(i_flush), .o_tdata(o_tdata),
        .o_tvalid(o_tvalid), .i_tready(i_tready), .o_level(o_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_tvalid = '0; i_tdata = '0; i_flush = 1'b0; i_tready = 1'b1;
        #1;
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", o_tvalid); end
        checks++; if (o_tdata !== 24'h0) begin errors++; $display("FAIL reset_tdata got=%h exp=000000", o_tdata); end
        checks++; if (o_tready !== 3'b000) begin errors++; $display("FAIL reset_tready got=%b exp=000", o_tready); end
        checks++; if (o_level !== 9'h0) begin errors++; $display("FAIL reset_level got=%h exp=000", o_level); end
        step();
        rst = 1'b0;
        step();
        checks++; if (o_tready !== 3'b111) begin errors++; $display("FAIL release_tready got=%b exp=111", o_tready); end
    endtask

    task automatic test_basic();
        i_tready = 1'b1;
        i_tvalid = 3'b111; i_tdata = 24'h332211;
        step();
        i_tvalid = '0;
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL basic_latency got=%b exp=0", o_tvalid); end
        checks++; if (o_level !== 9'b001_001_001) begin errors++; $display("FAIL basic_level1 got=%b exp=001001001", o_level); end
        step();
        checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL basic_tvalid got=%b exp=1", o_tvalid); end
        checks++; if (o_tdata !== 24'h332211) begin errors++; $display("FAIL basic_tdata got=%h exp=332211", o_tdata); end
        checks++; if (o_level !== 9'h0) begin errors++; $display("FAIL basic_level0 got=%b exp=0", o_level); end
        step();
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL basic_drop got=%b exp=0", o_tvalid); end
        checks++; if (o_tdata !== 24'h332211) begin errors++; $display("FAIL basic_hold got=%h exp=332211", o_tdata); end
    endtask

    task automatic test_skew();
        int nb;
        logic [23:0] exp;
        i_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_tvalid = 3'b001; i_tdata = {16'h0, 8'hA0 + 8'(i)};
            step();
        end
        i_tvalid = '0;
        checks++; if (o_tready !== 3'b110) begin errors++; $display("FAIL skew_tready got=%b exp=110", o_tready); end
        checks++; if (o_level !== 9'b000_000_100) begin errors++; $display("FAIL skew_level got=%b exp=000000100", o_level); end
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL skew_novalid got=%b exp=0", o_tvalid); end
        nb = 0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                i_tvalid = 3'b110; i_tdata = {8'hC0 + 8'(c), 8'hB0 + 8'(c), 8'h00};
            end else begin
                i_tvalid = '0;
            end
            step();
            if (o_tvalid === 1'b1) begin
                exp = {8'hC0 + 8'(nb), 8'hB0 + 8'(nb), 8'hA0 + 8'(nb)};
                checks++; if (o_tdata !== exp) begin errors++; $display("FAIL skew_beat%0d got=%h exp=%h", nb, o_tdata, exp); end
                nb++;
            end
        end
        checks++; if (nb !== 4) begin errors++; $display("FAIL skew_count got=%0d exp=4", nb); end
        checks++; if (o_tready !== 3'b111) begin errors++; $display("FAIL skew_ready_back got=%b exp=111", o_tready); end
    endtask

    task automatic test_backpressure();
        i_tready = 1'b0;
        i_tvalid = 3'b111; i_tdata = 24'h030201;
        step();
        i_tdata = 24'h131211;
        step();
        i_tvalid = '0;
        for (int c = 0; c < 10; c++) begin
            checks++; if (o_tvalid !== 1'b1 || o_tdata !== 24'h030201) begin
                errors++; $display("FAIL bp_hold%0d got=%b/%h exp=1/030201", c, o_tvalid, o_tdata);
            end
            step();
        end
        checks++; if (o_level !== 9'b001_001_001) begin errors++; $display("FAIL bp_level got=%b exp=001001001", o_level); end
        i_tready = 1'b1;
        step();
        checks++; if (o_tvalid !== 1'b1 || o_tdata !== 24'h131211) begin
            errors++; $display("FAIL bp_beat1 got=%b/%h exp=1/131211", o_tvalid, o_tdata);
        end
        step();
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL bp_nodup got=%b exp=0", o_tvalid); end
    endtask

    task automatic test_full_simul();
        logic [23:0] exp;
        i_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_tvalid = 3'b111; i_tdata = {8'h70 + 8'(i), 8'h60 + 8'(i), 8'h50 + 8'(i)};
            step();
        end
        i_tvalid = '0;
        checks++; if (o_level !== 9'b100_100_100) begin errors++; $display("FAIL full_level got=%b exp=100100100", o_level); end
        checks++; if (o_tready !== 3'b000) begin errors++; $display("FAIL full_tready got=%b exp=000", o_tready); end
        checks++; if (o_tvalid !== 1'b1 || o_tdata !== 24'h706050) begin
            errors++; $display("FAIL full_head got=%b/%h exp=1/706050", o_tvalid, o_tdata);
        end
        i_tready = 1'b1;
        step();
        i_tready = 1'b0;
        checks++; if (o_tready !== 3'b111) begin errors++; $display("FAIL pulse_tready got=%b exp=111", o_tready); end
        checks++; if (o_level !== 9'b011_011_011) begin errors++; $display("FAIL pulse_level got=%b exp=011011011", o_level); end
        checks++; if (o_tdata !== 24'h716151) begin errors++; $display("FAIL pulse_tdata got=%h exp=716151", o_tdata); end
        i_tready = 1'b1; i_tvalid = 3'b111; i_tdata = 24'h756555;
        step();
        checks++; if (o_level !== 9'b011_011_011) begin errors++; $display("FAIL simul_level got=%b exp=011011011", o_level); end
        checks++; if (o_tdata !== 24'h726252) begin errors++; $display("FAIL simul_tdata got=%h exp=726252", o_tdata); end
        i_tready = 1'b0; i_tdata = 24'h766656;
        step();
        i_tvalid = '0;
        checks++; if (o_level !== 9'b100_100_100) begin errors++; $display("FAIL refill_level got=%b exp=100100100", o_level); end
        checks++; if (o_tready !== 3'b000) begin errors++; $display("FAIL refill_tready got=%b exp=000", o_tready); end
        i_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp = {8'h73 + 8'(i), 8'h63 + 8'(i), 8'h53 + 8'(i)};
            checks++; if (o_tvalid !== 1'b1 || o_tdata !== exp) begin
                errors++; $display("FAIL drain%0d got=%b/%h exp=1/%h", i, o_tvalid, o_tdata, exp);
            end
        end
        step();
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL drain_end got=%b exp=0", o_tvalid); end
    endtask

    task automatic test_flush();
        i_tready = 1'b0;
        i_tvalid = 3'b111; i_tdata = 24'h929190;
        step();
        i_tvalid = 3'b011; i_tdata = 24'h008180;
        step();
        i_tvalid = 3'b001; i_tdata = 24'h000082;
        step();
        i_tdata = 24'h000083;
        step();
        i_tvalid = '0;
        checks++; if (o_level !== 9'b000_001_011) begin errors++; $display("FAIL preflush_level got=%b exp=000001011", o_level); end
        checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL preflush_tvalid got=%b exp=1", o_tvalid); end
        i_flush = 1'b1; i_tvalid = 3'b111; i_tdata = 24'hE2E1E0;
        step();
        i_flush = 1'b0; i_tvalid = '0;
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL flush_tvalid got=%b exp=0", o_tvalid); end
        checks++; if (o_level !== 9'h0) begin errors++; $display("FAIL flush_level got=%b exp=0", o_level); end
        checks++; if (o_tready !== 3'b111) begin errors++; $display("FAIL flush_tready got=%b exp=111", o_tready); end
        checks++; if (o_tdata !== 24'h929190) begin errors++; $display("FAIL flush_tdata_kept got=%h exp=929190", o_tdata); end
        i_tready = 1'b1; i_tvalid = 3'b111; i_tdata = 24'hF2F1F0;
        step();
        i_tvalid = '0;
        step();
        checks++; if (o_tvalid !== 1'b1 || o_tdata !== 24'hF2F1F0) begin
            errors++; $display("FAIL postflush_beat got=%b/%h exp=1/f2f1f0", o_tvalid, o_tdata);
        end
        step();
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL postflush_end got=%b exp=0", o_tvalid); end
    endtask

    task automatic test_midreset();
        i_tready = 1'b0;
        i_tvalid = 3'b111; i_tdata = 24'h232221;
        step();
        step();
        i_tvalid = '0;
        checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL prereset_tvalid got=%b exp=1", o_tvalid); end
        rst = 1'b1;
        #1;
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL areset_tvalid got=%b exp=0", o_tvalid); end
        checks++; if (o_tdata !== 24'h0) begin errors++; $display("FAIL areset_tdata got=%h exp=000000", o_tdata); end
        checks++; if (o_tready !== 3'b000) begin errors++; $display("FAIL areset_tready got=%b exp=000", o_tready); end
        checks++; if (o_level !== 9'h0) begin errors++; $display("FAIL areset_level got=%b exp=0", o_level); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (o_tready !== 3'b000) begin errors++; $display("FAIL release_early got=%b exp=000", o_tready); end
        step();
        checks++; if (o_tready !== 3'b111) begin errors++; $display("FAIL release_edge got=%b exp=111", o_tready); end
        i_tready = 1'b1; i_tvalid = 3'b111; i_tdata = 24'h070605;
        step();
        i_tvalid = '0;
        step();
        checks++; if (o_tvalid !== 1'b1 || o_tdata !== 24'h070605) begin
            errors++; $display("FAIL fresh_beat got=%b/%h exp=1/070605", o_tvalid, o_tdata);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_backpressure();
        test_full_simul();
        test_flush();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
